// File: rtl/reg_filter_writes.sv
// Write filter and watchdog sitting between a bus-to-reg bridge and a register file.
// Rejected-strobe writes are answered locally; stalled forwarded transactions are aborted.
package reg_filter_writes_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module reg_filter_writes
  import reg_filter_writes_pkg::*;
#(
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t,
  parameter int          AddrWidth     = 32,
  parameter int          DataWidth     = 32,
  parameter bit          FilterPartial = 1'b0,
  parameter bit          ErrorOnFilter = 1'b0,
  parameter int unsigned TimeoutCycles = 0,
  parameter int          CntWidth      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  req_t                 in_req_i,
  output rsp_t                 in_rsp_o,
  output req_t                 out_req_o,
  input  rsp_t                 out_rsp_i,
  input  logic                 cnt_clear_i,
  output logic [CntWidth-1:0]  filtered_cnt_o,
  output logic [CntWidth-1:0]  timeout_cnt_o,
  output logic [AddrWidth-1:0] last_filt_addr_o,
  output logic                 filtered_o,
  output logic                 timeout_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam bit WdEnable  = (TimeoutCycles != 0);
  // Counter only has to reach TimeoutCycles-1 before the abort is taken.
  localparam int WdWidth   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, FWD, ACK, TOUT} state_e;

  state_e               state_q, state_d;
  logic [WdWidth-1:0]   wd_q, wd_d;
  logic [CntWidth-1:0]  filt_cnt_q, filt_cnt_d;
  logic [CntWidth-1:0]  tout_cnt_q, tout_cnt_d;
  logic [AddrWidth-1:0] last_addr_q, last_addr_d;

  logic strb_zero, strb_full, is_filtered;

  assign strb_zero   = (in_req_i.wstrb == {StrbWidth{1'b0}});
  assign strb_full   = (in_req_i.wstrb == {StrbWidth{1'b1}});
  assign is_filtered = in_req_i.valid && in_req_i.write &&
                       (FilterPartial ? !strb_full : strb_zero);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    filt_cnt_d  = filt_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    last_addr_d = last_addr_q;
    out_req_o   = in_req_i;
    in_rsp_o    = out_rsp_i;

    case (state_q)
      IDLE: begin
        if (is_filtered) begin
          out_req_o.valid = 1'b0;
          in_rsp_o.ready  = 1'b0;
          last_addr_d     = in_req_i.addr;
          state_d         = ACK;
        end else if (in_req_i.valid && !out_rsp_i.ready) begin
          wd_d    = WdWidth'(1);
          state_d = (TimeoutCycles == 1) ? TOUT : FWD;
        end
      end
      FWD: begin
        if (out_rsp_i.ready) begin
          state_d = IDLE;
        end else if (WdEnable && (wd_q == WdLast)) begin
          state_d = TOUT;
        end else if (WdEnable) begin
          wd_d = wd_q + WdWidth'(1);
        end
      end
      ACK: begin
        out_req_o.valid = 1'b0;
        in_rsp_o.ready  = 1'b1;
        in_rsp_o.error  = ErrorOnFilter;
        in_rsp_o.rdata  = {DataWidth{1'b0}};
        if (filt_cnt_q != {CntWidth{1'b1}}) filt_cnt_d = filt_cnt_q + CntWidth'(1);
        state_d = IDLE;
      end
      TOUT: begin
        // Dropping valid downstream here deliberately aborts the stalled access.
        out_req_o.valid = 1'b0;
        in_rsp_o.ready  = 1'b1;
        in_rsp_o.error  = 1'b1;
        in_rsp_o.rdata  = {DataWidth{1'b0}};
        if (tout_cnt_q != {CntWidth{1'b1}}) tout_cnt_d = tout_cnt_q + CntWidth'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cnt_clear_i) begin
      filt_cnt_d = '0;
      tout_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      filt_cnt_q  <= '0;
      tout_cnt_q  <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      filt_cnt_q  <= filt_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign filtered_cnt_o   = filt_cnt_q;
  assign timeout_cnt_o    = tout_cnt_q;
  assign last_filt_addr_o = last_addr_q;
  assign filtered_o       = (state_q == ACK);
  assign timeout_o        = (state_q == TOUT);

endmodule

// File: tb/tb_reg_filter_writes.sv
// Directed bench: instance A uses default parameters, instance B uses
// partial filtering with error responses, a 4-cycle watchdog and 2-bit counters.
module tb_reg_filter_writes;
  import reg_filter_writes_pkg::*;

  logic clk = 1'b0;
  logic rst;

  reg_req_t req_a, req_b, oreq_a, oreq_b;
  reg_rsp_t dn_a, dn_b, up_a, up_b;
  logic clr_a, clr_b;
  logic [15:0] fc_a, tc_a;
  logic [1:0]  fc_b, tc_b;
  logic [31:0] la_a, la_b;
  logic fo_a, to_a, fo_b, to_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  reg_filter_writes u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(req_a), .in_rsp_o(up_a),
    .out_req_o(oreq_a), .out_rsp_i(dn_a),
    .cnt_clear_i(clr_a),
    .filtered_cnt_o(fc_a), .timeout_cnt_o(tc_a),
    .last_filt_addr_o(la_a),
    .filtered_o(fo_a), .timeout_o(to_a)
  );

  reg_filter_writes #(
    .FilterPartial(1'b1), .ErrorOnFilter(1'b1),
    .TimeoutCycles(4), .CntWidth(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(req_b), .in_rsp_o(up_b),
    .out_req_o(oreq_b), .out_rsp_i(dn_b),
    .cnt_clear_i(clr_b),
    .filtered_cnt_o(fc_b), .timeout_cnt_o(tc_b),
    .last_filt_addr_o(la_b),
    .filtered_o(fo_b), .timeout_o(to_b)
  );

  function automatic reg_req_t mkReq(input logic [31:0] addr, input logic write,
                                     input logic [3:0] strb, input logic valid);
    reg_req_t r;
    r.addr  = addr;
    r.write = write;
    r.wdata = 32'h1234_5678;
    r.wstrb = strb;
    r.valid = valid;
    return r;
  endfunction

  function automatic reg_rsp_t mkRsp(input logic [31:0] rdata, input logic error,
                                     input logic ready);
    reg_rsp_t r;
    r.rdata = rdata;
    r.error = error;
    r.ready = ready;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else passes++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    req_a = mkReq(32'h123, 1'b0, 4'h0, 1'b0);
    req_b = mkReq(32'h0, 1'b0, 4'h0, 1'b0);
    dn_a  = mkRsp(32'h77, 1'b0, 1'b1);
    dn_b  = mkRsp(32'h0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    sample();
    checkOutput("rst_fcnt_a", 32'(fc_a), 0);
    checkOutput("rst_tcnt_a", 32'(tc_a), 0);
    checkOutput("rst_last_a", la_a, 0);
    checkOutput("rst_pulses_a", {30'd0, fo_a, to_a}, 0);
    checkOutput("rst_req_mirror", oreq_a.addr, 32'h123);
    checkOutput("rst_rsp_mirror", up_a.rdata, 32'h77);

    // A: zero-strobe write is filtered, answered one cycle later with OK
    applyStimulus();
    rst   = 1'b0;
    req_a = mkReq(32'h40, 1'b1, 4'h0, 1'b1);
    dn_a  = mkRsp(32'h55, 1'b0, 1'b1);
    sample();
    checkOutput("t1_outvalid", 32'(oreq_a.valid), 0);
    checkOutput("t1_noready", 32'(up_a.ready), 0);
    applyStimulus();
    sample();
    checkOutput("t1_ack_ready", 32'(up_a.ready), 1);
    checkOutput("t1_ack_error", 32'(up_a.error), 0);
    checkOutput("t1_ack_rdata", up_a.rdata, 0);
    checkOutput("t1_pulse", 32'(fo_a), 1);
    checkOutput("t1_ack_outvalid", 32'(oreq_a.valid), 0);
    checkOutput("t1_last_addr", la_a, 32'h40);
    applyStimulus();
    req_a.valid = 1'b0;
    sample();
    checkOutput("t1_fcnt", 32'(fc_a), 1);
    checkOutput("t1_pulse_end", 32'(fo_a), 0);

    // A: partial strobe is forwarded with zero latency when only zero strobes filter
    applyStimulus();
    req_a = mkReq(32'h44, 1'b1, 4'h3, 1'b1);
    dn_a  = mkRsp(32'hABCD, 1'b0, 1'b1);
    sample();
    checkOutput("t2_outvalid", 32'(oreq_a.valid), 1);
    checkOutput("t2_outaddr", oreq_a.addr, 32'h44);
    checkOutput("t2_ready", 32'(up_a.ready), 1);
    checkOutput("t2_rdata", up_a.rdata, 32'hABCD);
    applyStimulus();
    req_a.valid = 1'b0;
    dn_a.ready  = 1'b0;
    sample();
    checkOutput("t2_fcnt", 32'(fc_a), 1);
    checkOutput("t2_no_pulse", 32'(fo_a), 0);

    // A: read with zero strobe is forwarded; watchdog disabled, completes in cycle 3
    applyStimulus();
    req_a = mkReq(32'h48, 1'b0, 4'h0, 1'b1);
    dn_a  = mkRsp(32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput($sformatf("t3_fwd_valid_%0d", c), 32'(oreq_a.valid), 1);
      checkOutput($sformatf("t3_wait_ready_%0d", c), 32'(up_a.ready), 0);
      applyStimulus();
    end
    dn_a = mkRsp(32'hCAFE, 1'b0, 1'b1);
    sample();
    checkOutput("t3_ready", 32'(up_a.ready), 1);
    checkOutput("t3_rdata", up_a.rdata, 32'hCAFE);
    applyStimulus();
    req_a.valid = 1'b0;
    dn_a.ready  = 1'b0;
    sample();
    checkOutput("t3_fcnt", 32'(fc_a), 1);
    checkOutput("t3_tcnt", 32'(tc_a), 0);

    // B: partial strobe filtered with an error response
    applyStimulus();
    req_b = mkReq(32'h80, 1'b1, 4'h3, 1'b1);
    sample();
    checkOutput("b1_outvalid", 32'(oreq_b.valid), 0);
    applyStimulus();
    sample();
    checkOutput("b1_ready", 32'(up_b.ready), 1);
    checkOutput("b1_error", 32'(up_b.error), 1);
    checkOutput("b1_pulse", 32'(fo_b), 1);
    applyStimulus();
    req_b.valid = 1'b0;
    sample();
    checkOutput("b1_fcnt", 32'(fc_b), 1);

    // B: downstream never ready, abort after 4 forwarded cycles
    applyStimulus();
    req_b = mkReq(32'h90, 1'b1, 4'hF, 1'b1);
    dn_b  = mkRsp(32'h5, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      sample();
      checkOutput($sformatf("b2_valid_%0d", c), 32'(oreq_b.valid), 1);
      checkOutput($sformatf("b2_noready_%0d", c), 32'(up_b.ready), 0);
      applyStimulus();
    end
    sample();
    checkOutput("b2_tout_outvalid", 32'(oreq_b.valid), 0);
    checkOutput("b2_tout_ready", 32'(up_b.ready), 1);
    checkOutput("b2_tout_error", 32'(up_b.error), 1);
    checkOutput("b2_tout_rdata", up_b.rdata, 0);
    checkOutput("b2_tout_pulse", 32'(to_b), 1);
    applyStimulus();
    req_b.valid = 1'b0;
    sample();
    checkOutput("b2_tcnt", 32'(tc_b), 1);
    checkOutput("b2_pulse_end", 32'(to_b), 0);

    // B: downstream ready in the last forwarded cycle beats the watchdog
    applyStimulus();
    req_b = mkReq(32'h94, 1'b1, 4'hF, 1'b1);
    dn_b  = mkRsp(32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput($sformatf("b3_noready_%0d", c), 32'(up_b.ready), 0);
      applyStimulus();
    end
    dn_b = mkRsp(32'h9, 1'b0, 1'b1);
    sample();
    checkOutput("b3_ready", 32'(up_b.ready), 1);
    checkOutput("b3_error", 32'(up_b.error), 0);
    checkOutput("b3_rdata", up_b.rdata, 32'h9);
    checkOutput("b3_no_pulse", 32'(to_b), 0);
    applyStimulus();
    req_b.valid = 1'b0;
    dn_b.ready  = 1'b0;
    sample();
    checkOutput("b3_no_late_pulse", 32'(to_b), 0);
    checkOutput("b3_tcnt", 32'(tc_b), 1);

    // B: clear, then saturate the 2-bit filtered counter
    applyStimulus();
    clr_b = 1'b1;
    applyStimulus();
    clr_b = 1'b0;
    sample();
    checkOutput("b4_clr_fcnt", 32'(fc_b), 0);
    checkOutput("b4_clr_tcnt", 32'(tc_b), 0);
    checkOutput("b4_clr_last", la_b, 32'h80);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus();
      req_b = mkReq(32'h100 + 32'(k * 4), 1'b1, 4'h0, 1'b1);
      sample();
      checkOutput($sformatf("b4_noready_%0d", k), 32'(up_b.ready), 0);
      applyStimulus();
      sample();
      checkOutput($sformatf("b4_pulse_%0d", k), 32'(fo_b), 1);
      applyStimulus();
      req_b.valid = 1'b0;
      sample();
      checkOutput($sformatf("b4_fcnt_%0d", k), 32'(fc_b), (k < 3) ? k : 3);
    end
    checkOutput("b4_last", la_b, 32'h114);

    // B: clear coincident with an ACK wins over the increment
    applyStimulus();
    req_b = mkReq(32'h1A0, 1'b1, 4'h3, 1'b1);
    applyStimulus();
    clr_b = 1'b1;
    sample();
    checkOutput("b5_pulse", 32'(fo_b), 1);
    applyStimulus();
    clr_b       = 1'b0;
    req_b.valid = 1'b0;
    sample();
    checkOutput("b5_fcnt", 32'(fc_b), 0);
    checkOutput("b5_last", la_b, 32'h1A0);

    // B: reset during FWD abandons the transaction; held request restarts from IDLE
    applyStimulus();
    req_b = mkReq(32'hA0, 1'b1, 4'hF, 1'b1);
    dn_b  = mkRsp(32'h0, 1'b0, 1'b0);
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    sample();
    checkOutput("r_noready", 32'(up_b.ready), 0);
    checkOutput("r_mirror_valid", 32'(oreq_b.valid), 1);
    checkOutput("r_fcnt_a", 32'(fc_a), 0);
    checkOutput("r_no_pulse", 32'(to_b), 0);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      checkOutput($sformatf("r_valid_%0d", c), 32'(oreq_b.valid), 1);
      checkOutput($sformatf("r_noready_%0d", c), 32'(up_b.ready), 0);
      applyStimulus();
    end
    sample();
    checkOutput("r_tout_pulse", 32'(to_b), 1);
    checkOutput("r_tout_error", 32'(up_b.error), 1);
    applyStimulus();
    req_b.valid = 1'b0;
    sample();
    checkOutput("r_tcnt", 32'(tc_b), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
